// File: rtl/pipeline_debug_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_debug_pkg - controller state encoding and command/response codes
// Rev 1.0
// ============================================================================
package pipeline_debug_pkg;

    typedef enum logic [2:0] {
        ST_PRST = 3'd0,
        ST_IDLE = 3'd1,
        ST_STEP = 3'd2,
        ST_RUN  = 3'd3,
        ST_RESP = 3'd4,
        ST_DUMP = 3'd5
    } state_t;

    localparam logic [7:0] CMD_RESET   = 8'h43;
    localparam logic [7:0] CMD_STEP    = 8'h53;
    localparam logic [7:0] CMD_RUN     = 8'h52;
    localparam logic [7:0] CMD_DUMP    = 8'h44;

    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_HALT    = 8'h48;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] RSP_ERR     = 8'h3F;

    localparam int NUM_DBG_WORDS = 5;

endpackage
`default_nettype wire

// File: rtl/debug_dump_serializer.sv
`default_nettype none
// ============================================================================
// debug_dump_serializer - snapshot register streamed out LSB byte first
// Rev 1.0
// ============================================================================
module debug_dump_serializer #(
    parameter int NUM_BYTES = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [NUM_BYTES*8-1:0] snapshot,
    input  logic                   start,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   done
);

    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    logic [NUM_BYTES*8-1:0] r_snap;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_next_idx;

    assign w_next_idx = r_idx + 1'b1;
    assign done       = tx_valid & tx_ready & (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap   <= '0;
            r_idx    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (load) begin
                r_snap <= snapshot;
            end
            if (start) begin
                r_idx    <= '0;
                tx_valid <= 1'b1;
                tx_data  <= r_snap[7:0];
            end else if (tx_valid && tx_ready) begin
                // Data only moves on a completed transfer, so it stays stable while stalled.
                if (r_idx == LAST_IDX) begin
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                end else begin
                    r_idx   <= w_next_idx;
                    tx_data <= r_snap[{w_next_idx, 3'b000} +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_debug_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_debug_ctrl - byte-command run/step/reset/dump sequencer for the core
// Rev 1.0
// ============================================================================
module pipeline_debug_ctrl
    import pipeline_debug_pkg::*;
#(
    parameter int                  DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter int                  RUN_LIMIT    = 1024,
    parameter int                  RESET_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] dbg_pc,
    input  logic [DATA_WIDTH-1:0] dbg_instr,
    input  logic [DATA_WIDTH-1:0] dbg_w_data,
    input  logic [DATA_WIDTH-1:0] dbg_rs_data,
    input  logic [DATA_WIDTH-1:0] dbg_rt_data,
    output logic                  pc_enable,
    output logic                  pc_reset,
    output logic                  busy,
    output logic                  halted
);

    localparam int NUM_BYTES = NUM_DBG_WORDS * DATA_WIDTH / 8;
    localparam int RUN_CW    = $clog2(RUN_LIMIT) + 1;
    localparam int PRST_CW   = $clog2(RESET_CYCLES) + 1;
    localparam logic [RUN_CW-1:0]  RUN_LAST  = RUN_CW'(RUN_LIMIT - 1);
    localparam logic [PRST_CW-1:0] PRST_LAST = PRST_CW'(RESET_CYCLES - 1);

    state_t               r_state;
    logic [PRST_CW-1:0]   r_prst_cnt;
    logic                 r_prst_resp;
    logic [RUN_CW-1:0]    r_run_cnt;
    logic                 r_rsp_valid;
    logic [7:0]           r_rsp_data;

    logic                 w_at_halt;
    logic                 w_dump_load;
    logic                 w_dump_start;
    logic                 w_dump_done;
    logic                 w_ser_valid;
    logic [7:0]           w_ser_data;

    assign w_at_halt    = (dbg_instr == HALT_INSTR);
    assign rx_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign pc_reset     = (r_state == ST_PRST);
    assign pc_enable    = ((r_state == ST_STEP) || (r_state == ST_RUN)) && !w_at_halt;
    assign w_dump_load  = (r_state == ST_IDLE) && rx_valid && (rx_data == CMD_DUMP);
    assign w_dump_start = (r_state == ST_DUMP) && !w_ser_valid;

    // Only one source is ever valid; both registers idle at zero.
    assign tx_valid = r_rsp_valid | w_ser_valid;
    assign tx_data  = r_rsp_valid ? r_rsp_data : w_ser_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_PRST;
            r_prst_cnt  <= '0;
            r_prst_resp <= 1'b0;
            r_run_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            halted      <= 1'b0;
        end else begin
            case (r_state)
                ST_PRST: begin
                    if (r_prst_cnt == PRST_LAST) begin
                        r_prst_cnt <= '0;
                        // The power-on reset sequence goes quietly to IDLE.
                        if (r_prst_resp) begin
                            r_prst_resp <= 1'b0;
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= RSP_OK;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_prst_cnt <= r_prst_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_RESET: begin
                                r_state     <= ST_PRST;
                                r_prst_cnt  <= '0;
                                r_prst_resp <= 1'b1;
                                halted      <= 1'b0;
                            end
                            CMD_STEP: r_state <= ST_STEP;
                            CMD_RUN: begin
                                r_state   <= ST_RUN;
                                r_run_cnt <= '0;
                                halted    <= 1'b0;
                            end
                            CMD_DUMP: r_state <= ST_DUMP;
                            default: begin
                                r_state     <= ST_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= RSP_ERR;
                            end
                        endcase
                    end
                end
                ST_STEP: begin
                    r_state     <= ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_at_halt ? RSP_HALT : RSP_OK;
                end
                ST_RUN: begin
                    if (w_at_halt) begin
                        halted      <= 1'b1;
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= RSP_HALT;
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                        if (r_run_cnt == RUN_LAST) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= RSP_TIMEOUT;
                        end
                    end
                end
                ST_RESP: begin
                    if (tx_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DUMP: begin
                    if (w_dump_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_PRST;
            endcase
        end
    end

    debug_dump_serializer #(
        .NUM_BYTES (NUM_BYTES)
    ) u_dump (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (w_dump_load),
        .snapshot ({dbg_rt_data, dbg_rs_data, dbg_w_data, dbg_instr, dbg_pc}),
        .start    (w_dump_start),
        .tx_valid (w_ser_valid),
        .tx_data  (w_ser_data),
        .tx_ready (tx_ready),
        .done     (w_dump_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_debug_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_debug_ctrl - directed self-checking bench for the debug controller
// Rev 1.0
// ============================================================================
module tb_pipeline_debug_ctrl;

    localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR = 32'h2002_0005;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] dbg_pc, dbg_instr, dbg_w_data, dbg_rs_data, dbg_rt_data;
    logic        pc_enable, pc_reset, busy, halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_debug_ctrl #(
        .DATA_WIDTH   (32),
        .HALT_INSTR   (HALT),
        .RUN_LIMIT    (8),
        .RESET_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .dbg_pc      (dbg_pc),
        .dbg_instr   (dbg_instr),
        .dbg_w_data  (dbg_w_data),
        .dbg_rs_data (dbg_rs_data),
        .dbg_rt_data (dbg_rt_data),
        .pc_enable   (pc_enable),
        .pc_reset    (pc_reset),
        .busy        (busy),
        .halted      (halted)
    );

    // Present one byte for a single accepting edge.
    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
    endtask

    // Runs cycles after a command until a response byte shows; instr turns to HALT
    // once (halt_at-1) enables have been seen (halt_at==0: never).
    task automatic collect(input int halt_at, output logic [7:0] rsp, output int en,
                           output int rst_cyc, output bit got);
        en = 0; rst_cyc = 0; got = 1'b0; rsp = 8'h00;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rx_valid  = 1'b0;
            dbg_instr = (halt_at != 0 && en >= halt_at - 1) ? HALT : NOP_INSTR;
            #1;
            if (pc_enable) en++;
            if (pc_reset) rst_cyc++;
            if (tx_valid) begin
                rsp = tx_data;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        bit tx_seen;
        reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        dbg_pc = '0; dbg_instr = NOP_INSTR; dbg_w_data = '0; dbg_rs_data = '0; dbg_rt_data = '0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (pc_reset !== 1'b1) begin bad++; $display("FAIL reset_pc_reset: got %b want 1", pc_reset); end
        total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL reset_pc_enable: got %b want 0", pc_enable); end
        total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        @(negedge clk);
        reset_n = 1'b1;
        n = 0; tx_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (pc_reset) n++;
            if (tx_valid) tx_seen = 1'b1;
            @(negedge clk);
        end
        #1;
        total++; if (n != 2) begin bad++; $display("FAIL reset_release_cycles: got %0d want 2", n); end
        total++; if (tx_seen !== 1'b0) begin bad++; $display("FAIL reset_release_tx: got %b want 0", tx_seen); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL reset_release_rx_ready: got %b want 1", rx_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_step;
        logic [7:0] rsp; int en, rc; bit got;
        send_cmd(8'h53);
        collect(0, rsp, en, rc, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL step_got: got %b want 1", got); end
        total++; if (en != 1) begin bad++; $display("FAIL step_enables: got %0d want 1", en); end
        total++; if (rsp !== 8'h4B) begin bad++; $display("FAIL step_rsp: got %h want 4b", rsp); end
    endtask

    task automatic test_run_halt;
        logic [7:0] rsp; int en, rc; bit got;
        send_cmd(8'h52);
        collect(5, rsp, en, rc, got);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL halt_got: got %b want 1", got); end
        total++; if (en != 4) begin bad++; $display("FAIL halt_enables: got %0d want 4", en); end
        total++; if (rsp !== 8'h48) begin bad++; $display("FAIL halt_rsp: got %h want 48", rsp); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b want 1", halted); end
        send_cmd(8'h53);
        collect(1, rsp, en, rc, got);
        total++; if (en != 0) begin bad++; $display("FAIL step_at_halt_enables: got %0d want 0", en); end
        total++; if (rsp !== 8'h48 || got !== 1'b1) begin bad++; $display("FAIL step_at_halt_rsp: got %h want 48", rsp); end
    endtask

    task automatic test_run_limit;
        logic [7:0] rsp; int en, rc; bit got;
        send_cmd(8'h52);
        collect(0, rsp, en, rc, got);
        total++; if (en != 8) begin bad++; $display("FAIL limit_enables: got %0d want 8", en); end
        total++; if (rsp !== 8'h54 || got !== 1'b1) begin bad++; $display("FAIL limit_rsp: got %h want 54", rsp); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL limit_halted: got %b want 0", halted); end
    endtask

    task automatic test_reset_cmd;
        logic [7:0] rsp; int en, rc; bit got;
        send_cmd(8'h52);
        collect(1, rsp, en, rc, got);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL cmd_reset_pre_halted: got %b want 1", halted); end
        send_cmd(8'h43);
        collect(0, rsp, en, rc, got);
        total++; if (rc != 2) begin bad++; $display("FAIL cmd_reset_cycles: got %0d want 2", rc); end
        total++; if (rsp !== 8'h4B || got !== 1'b1) begin bad++; $display("FAIL cmd_reset_rsp: got %h want 4b", rsp); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL cmd_reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_unknown;
        logic [7:0] rsp; int en, rc; bit got;
        send_cmd(8'h5A);
        collect(0, rsp, en, rc, got);
        total++; if (rsp !== 8'h3F || got !== 1'b1) begin bad++; $display("FAIL unknown_rsp: got %h want 3f", rsp); end
        total++; if (en != 0) begin bad++; $display("FAIL unknown_enables: got %0d want 0", en); end
    endtask

    task automatic test_busy_reject;
        logic [7:0] rsp; int en; bit got; bit extra;
        rsp = 8'h00; en = 0; got = 1'b0; extra = 1'b0;
        send_cmd(8'h52);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            dbg_instr = NOP_INSTR;
            rx_valid  = (i >= 2 && i <= 4);
            rx_data   = 8'h5A;
            #1;
            if (i == 3) begin
                total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL busy_rx_ready: got %b want 0", rx_ready); end
            end
            if (pc_enable) en++;
            if (tx_valid) begin rsp = tx_data; got = 1'b1; break; end
        end
        total++; if (en != 8) begin bad++; $display("FAIL busy_run_enables: got %0d want 8", en); end
        total++; if (rsp !== 8'h54 || got !== 1'b1) begin bad++; $display("FAIL busy_run_rsp: got %h want 54", rsp); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (tx_valid) extra = 1'b1;
        end
        total++; if (extra !== 1'b0) begin bad++; $display("FAIL busy_byte_consumed: got %b want 0", extra); end
    endtask

    task automatic test_dump;
        logic [159:0] exp_snap;
        logic [7:0]   prev_data;
        bit           prev_hold;
        int           nbytes;
        dbg_pc = 32'h0000_0010; dbg_instr = NOP_INSTR; dbg_w_data = 32'hA5A5_1234;
        dbg_rs_data = 32'h0000_00FF; dbg_rt_data = 32'hDEAD_BEEF;
        exp_snap = {dbg_rt_data, dbg_rs_data, dbg_w_data, dbg_instr, dbg_pc};
        tx_ready = 1'b0;
        send_cmd(8'h44);
        @(negedge clk);
        rx_valid = 1'b0;
        dbg_pc = 32'hFFFF_0000; dbg_w_data = 32'h0; dbg_rs_data = 32'h1111_1111; dbg_rt_data = 32'h0;
        nbytes = 0; prev_hold = 1'b0; prev_data = 8'h00;
        for (int c = 0; c < 100; c++) begin
            tx_ready = c[0];
            #1;
            if (prev_hold) begin
                total++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    bad++; $display("FAIL dump_stable: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, prev_data);
                end
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (tx_valid && tx_ready) begin
                total++;
                if (tx_data !== exp_snap[nbytes*8 +: 8]) begin
                    bad++; $display("FAIL dump_byte%0d: got %h want %h", nbytes, tx_data, exp_snap[nbytes*8 +: 8]);
                end
                nbytes++;
            end
            if (nbytes == 20) break;
            @(negedge clk);
        end
        total++; if (nbytes != 20) begin bad++; $display("FAIL dump_count: got %0d want 20", nbytes); end
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL dump_end_tx_valid: got %b want 0", tx_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dump_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_dump;
        tx_ready = 1'b0;
        send_cmd(8'h44);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL middump_pending: got %b want 1", tx_valid); end
        reset_n = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL middump_tx_valid: got %b want 0", tx_valid); end
        total++; if (pc_reset !== 1'b1) begin bad++; $display("FAIL middump_pc_reset: got %b want 1", pc_reset); end
        @(negedge clk);
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL middump_recover_rx_ready: got %b want 1", rx_ready); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL middump_recover_tx: got %b want 0", tx_valid); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_halt();
        test_run_limit();
        test_reset_cmd();
        test_unknown();
        test_busy_reject();
        test_dump();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
